// File: rtl/key_evt_ctrl_pkg.sv
// Shared constants, types and the round-robin pick function for the key event scheduler.
// Pure declarations: no state, no latency, no backpressure.
package key_evt_pkg;

  localparam int KEY_NUM        = 4;
  localparam int KEY_CODE_W     = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int OVF_W_DEF      = 8;

  typedef logic [KEY_CODE_W-1:0] key_code_t;
  typedef logic [KEY_NUM-1:0]    key_vec_t;

  typedef struct packed {
    logic      vld;
    key_code_t idx;
  } grant_t;

  // Lowest offset from ptr wins, so walk offsets from the far end and let nearer hits overwrite.
  function automatic grant_t rr_pick(input key_vec_t pend, input key_code_t ptr);
    grant_t    g;
    key_code_t k;
    g = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      k = ptr + key_code_t'(i);
      if (pend[k]) begin
        g.vld = 1'b1;
        g.idx = k;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/key_evt_ctrl_if.sv
// Processor-side event handshake: head key code with valid, consumed by ack.
// Combinational bundle only; backpressure is the processor withholding EVT_ACK.
interface key_evt_ctrl_if;
  import key_evt_pkg::*;

  logic      EVT_VALID;
  key_code_t EVT_CODE;
  logic      EVT_ACK;

  modport master (
    output EVT_VALID,
    output EVT_CODE,
    input  EVT_ACK
  );

  modport slave (
    input  EVT_VALID,
    input  EVT_CODE,
    output EVT_ACK
  );

endinterface

// File: rtl/key_evt_ctrl_fifo.sv
// Generic synchronous FIFO: push/pop with full/empty/count, head shown as zero when empty.
// Latency: write visible at head one edge after push; push when full / pop when empty are ignored.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign cnt_o      = cnt_q;
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/key_evt_ctrl.sv
// Collects switch pulses into PEND, grants one per cycle round-robin into the event FIFO, counts lost pulses.
// Latency 2 cycles pulse->EVT_VALID; backpressure: full FIFO holds PEND, repeat pulses on a held key count as lost.
module key_evt_ctrl
  import key_evt_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int OVF_W      = OVF_W_DEF,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  key_vec_t         PSW_SIG,
  input  logic             CLR_OVF,
  key_evt_ctrl_if.master   evt,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic [OVF_W-1:0] OVF_CNT,
  output logic             BUSY
);

  localparam int SUM_W = OVF_W + 3;
  localparam logic [SUM_W-1:0] OVF_MAX = {3'b000, {OVF_W{1'b1}}};

  key_vec_t         pend_q, pend_d;
  key_code_t        ptr_q, ptr_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  grant_t           grant;
  logic             gnt_en;
  key_vec_t         gnt_vec;
  key_vec_t         lost;
  logic [2:0]       lost_n;
  logic [OVF_W-1:0] ovf_base;
  logic [SUM_W-1:0] ovf_sum;

  logic             fifo_full, fifo_empty, fifo_pop;
  key_code_t        fifo_head;

  // Full is taken from registered occupancy: a pop this cycle does not free a slot for a grant.
  always_comb begin
    grant   = rr_pick(pend_q, ptr_q);
    gnt_en  = grant.vld & ~fifo_full;
    gnt_vec = '0;
    if (gnt_en) gnt_vec[grant.idx] = 1'b1;

    pend_d = (pend_q & ~gnt_vec) | PSW_SIG;
    ptr_d  = gnt_en ? grant.idx + key_code_t'(1) : ptr_q;

    lost   = PSW_SIG & pend_q & ~gnt_vec;
    lost_n = '0;
    for (int i = 0; i < KEY_NUM; i++) lost_n = lost_n + 3'(lost[i]);

    ovf_base = CLR_OVF ? '0 : ovf_q;
    ovf_sum  = SUM_W'(ovf_base) + SUM_W'(lost_n);
    ovf_d    = (ovf_sum > OVF_MAX) ? '1 : ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pend_q <= '0;
      ptr_q  <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fifo_pop = ~fifo_empty & evt.EVT_ACK;

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .push_i     (gnt_en),
    .push_dat_i (grant.idx),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .cnt_o      (EVT_CNT)
  );

  assign evt.EVT_VALID = ~fifo_empty;
  assign evt.EVT_CODE  = fifo_head;
  assign OVF_CNT       = ovf_q;
  assign BUSY          = (|pend_q) | ~fifo_empty;

endmodule

// File: doc/key_evt_ctrl.md
# key_evt_ctrl

Event scheduler between the four-channel push-switch chattering remover and the processor. Collects the single-cycle, high-pulse switch signals from all four channels, arbitrates them round-robin into a small event FIFO, and presents one key code at a time to the processor over a valid/ack handshake. Pulses that cannot be recorded are counted rather than silently lost.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- OVF_W, 8: width of the lost-event counter.

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  reset, asynchronous, active-low.
- PSW_SIG  in  4  debounced one-cycle high pulses, bit i = switch i; synchronous to CLK.
- EVT_ACK  in  1  processor consumes the head event when EVT_VALID=1.
- CLR_OVF  in  1  synchronous clear of OVF_CNT.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_CODE  out  2  key index of the head event; 0 when empty.
- EVT_CNT  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- OVF_CNT  out  OVF_W  saturating count of lost pulses.
- BUSY  out  1  PEND≠0 or EVT_VALID=1.

## Operation
- PEND[3:0] register: bit i is set at the edge sampling PSW_SIG[i]=1. Bit i is cleared at the edge where key i is granted, unless PSW_SIG[i]=1 in that same cycle, in which case it stays set as a new event.
- Arbiter: combinational from PEND and the registered PTR[1:0]. Search order is PTR, PTR+1, PTR+2, PTR+3 (mod 4). At most one grant per cycle.
- Grant condition: PEND≠0 and FIFO not full. Full is judged on the registered occupancy, so a pop in the same cycle does not enable a grant.
- On grant of key g: push g into the FIFO, clear PEND[g], set PTR←(g+1) mod 4.
- Pop: EVT_VALID & EVT_ACK at the edge removes the head. EVT_ACK while empty is ignored.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, order preserved.
- Lost pulse: PSW_SIG[i]=1 while PEND[i]=1 and key i is not granted that cycle. Each cycle, OVF_CNT increases by the number of lost bits and saturates at 2^OVF_W−1.
- CLR_OVF=1: OVF_CNT←(lost bits this cycle). The clear takes priority over the old value.
- Reset, asynchronous, including mid-operation: PEND=0, PTR=0, FIFO emptied (pointers 0), EVT_VALID=0, EVT_CODE=0, EVT_CNT=0, OVF_CNT=0, BUSY=0. Pulses present at reset release are sampled normally at the first edge.

## Timing
- Pulse sampled at edge k → PEND set after k → FIFO write at edge k+1 → EVT_VALID=1 after k+1. Latency is 2 cycles when the FIFO is not full.
- EVT_CODE/EVT_VALID are driven from registered FIFO state, with no combinational path from PSW_SIG or EVT_ACK.
- After a pop at edge m, the next entry, if any, is visible after m. Full throughput is one event per cycle in and out.
- All four keys pulsing together are drained to the FIFO over 4 consecutive cycles in round-robin order.

## Structure
- Package key_evt_pkg: KEY_NUM=4, KEY_CODE_W=2, default FIFO_DEPTH and OVF_W, and a function rr_pick(pend, ptr) returning grant valid plus index.
- Sub-module evt_fifo: synchronous FIFO with parameterised depth and width, push/pop/full/empty/count, asynchronous active-low reset.
- Top module: PEND register, PTR, arbiter, OVF counter and BUSY.

## Test plan
- Reset, then PSW_SIG=4'b0100 for 1 cycle → EVT_VALID=1 two edges later with EVT_CODE=2, EVT_CNT=1. After EVT_ACK for 1 cycle → EVT_VALID=0, BUSY=0.
- From reset, PSW_SIG=4'b1111 for 1 cycle, no ack → FIFO holds 0,1,2,3. Acking in order yields codes 0,1,2,3. OVF_CNT=0.
- Round-robin: after a grant of key 1, PEND=4'b0011 → next grants are 0 then 1 only if PTR order holds, i.e. order 0 at PTR=2 wrap. Check codes 0 then 1, with PTR=2 before and PTR=2 after.
- FIFO full (4 entries, no ack), then key 3 pulse → PEND[3]=1 held. A second key 3 pulse → OVF_CNT=1. One ack → key 3 written on the following edge.
- Pulse of key 0 in the same cycle it is granted → two key-0 events delivered, OVF_CNT=0. Saturation: 300 lost pulses with OVF_W=8 → OVF_CNT=255. CLR_OVF → 0.
- Assert RSTN low while 3 events are queued and PEND=4'b1010 → all outputs are 0 immediately (asynchronously). After release, no stale events are delivered.
